// File: rtl/nand_rr_scheduler.sv
// Round-robin arbiter sharing one bitwise NAND unit among NREQ requesters,
// with a single-entry registered result buffer under valid/ready backpressure.
module nand_rr_scheduler #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 4,
  parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*W-1:0]  op_a,
  input  logic [NREQ*W-1:0]  op_b,
  output logic [NREQ-1:0]    gnt,
  output logic               res_valid,
  output logic [W-1:0]       res_data,
  output logic [IDW-1:0]     res_id,
  input  logic               res_ready,
  output logic               busy,
  output logic [7:0]         op_count
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0]  CNT_MAX  = '1;
  localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0]      r_state;
  logic [W-1:0]    r_data;
  logic [IDW-1:0]  r_id;
  logic [IDW-1:0]  r_last;
  logic [CW-1:0]   r_count;

  logic [0:0]      w_state_nxt;
  logic [W-1:0]    w_data_nxt;
  logic [IDW-1:0]  w_id_nxt;
  logic [IDW-1:0]  w_last_nxt;
  logic [CW-1:0]   w_count_nxt;

  logic            w_can_issue;
  logic            w_xfer;
  logic            w_found;
  logic [IDW-1:0]  w_gnt_id;
  logic [NREQ-1:0] w_gnt;
  logic [W-1:0]    w_a;
  logic [W-1:0]    w_b;

  assign w_can_issue = (r_state == S_EMPTY) || res_ready;
  assign w_xfer      = (r_state == S_FULL) && res_ready;

  // Search starts one past the most recent grant and wraps modulo NREQ.
  always_comb begin
    int unsigned v_idx;
    logic [IDW-1:0] v_id;
    w_found  = 1'b0;
    w_gnt_id = '0;
    w_gnt    = '0;
    v_idx    = 0;
    v_id     = '0;
    if (w_can_issue && (|req)) begin
      for (int unsigned k = 1; k <= NREQ; k++) begin
        v_idx = (32'(r_last) + k) % NREQ;
        v_id  = IDW'(v_idx);
        if (!w_found && req[v_id]) begin
          w_found  = 1'b1;
          w_gnt_id = v_id;
        end
      end
    end
    if (w_found) begin
      w_gnt[w_gnt_id] = 1'b1;
    end
  end

  assign w_a = op_a[w_gnt_id*W +: W];
  assign w_b = op_b[w_gnt_id*W +: W];

  // Next-state and buffer update; a grant always overwrites a draining result.
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_id_nxt    = r_id;
    w_last_nxt  = r_last;
    w_count_nxt = r_count;

    if (w_xfer && (r_count != CNT_MAX)) begin
      w_count_nxt = r_count + CW'(1);
    end

    case (r_state)
      S_EMPTY: begin
        if (w_found) begin
          w_state_nxt = S_FULL;
          w_data_nxt  = ~(w_a & w_b);
          w_id_nxt    = w_gnt_id;
          w_last_nxt  = w_gnt_id;
        end
      end
      S_FULL: begin
        if (w_found) begin
          w_state_nxt = S_FULL;
          w_data_nxt  = ~(w_a & w_b);
          w_id_nxt    = w_gnt_id;
          w_last_nxt  = w_gnt_id;
        end else if (res_ready) begin
          w_state_nxt = S_EMPTY;
        end
      end
      default: begin
        w_state_nxt = S_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_data  <= '0;
      r_id    <= '0;
      r_last  <= LAST_RST;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_id    <= w_id_nxt;
      r_last  <= w_last_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign gnt       = w_gnt;
  assign res_valid = r_state[0];
  assign res_data  = r_data;
  assign res_id    = r_id;
  assign op_count  = r_count;
  assign busy      = r_state[0] | (|req);

endmodule

// File: doc/nand_rr_scheduler.md
# nand_rr_scheduler

Round-robin scheduler that shares one W-bit bitwise NAND evaluation unit between NREQ requesters. Each requester presents an operand pair with a request line. The block grants one requester per cycle, registers that requester's NAND result, and holds the result in a single-entry output buffer with valid/ready backpressure. It sits between the user-input decode logic and the output pins of the NAND tile, as the control layer that sequences access to the gate datapath.

## Interface
- NREQ, 4: number of requesters (2..8)
- W, 4: operand/result width in bits; the NAND is bitwise
- IDW, $clog2(NREQ): requester-index width (derived)

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  request vector; bit i = requester i has an operand pair ready
- op_a  in  NREQ*W  operand A; requester i at [i*W +: W]
- op_b  in  NREQ*W  operand B; requester i at [i*W +: W]
- gnt  out  NREQ  one-hot grant; combinational; bit i high = requester i's operands captured this edge
- res_valid  out  1  output buffer holds a result
- res_data  out  W  registered ~(op_a & op_b) of the granted requester
- res_id  out  IDW  index of the requester that produced res_data
- res_ready  in  1  consumer accepts the result on an edge where res_valid=1
- busy  out  1  res_valid | (|req)
- op_count  out  8  saturating count of completed transfers (res_valid & res_ready)

## Operation
- Two states, encoded by res_valid: EMPTY (0) and FULL (1).
- can_issue = !res_valid | res_ready.
- Round-robin pointer `last` (IDW bits) holds the index of the most recent grant.
- When can_issue & |req: gnt is one-hot at the first set req bit searching last+1, last+2, ... with wrap modulo NREQ. Otherwise gnt = 0.
- On an edge with gnt[i]=1:
  - res_data <= ~(op_a[i] & op_b[i])
  - res_id <= i
  - res_valid <= 1
  - last <= i
- On an edge with res_valid & res_ready and no grant: res_valid <= 0. res_data and res_id hold their values.
- Drain and grant on the same edge: the new result replaces the old one, res_valid stays 1, and the old result counts as delivered.
- No req: gnt = 0 and `last` is unchanged.
- FULL & !res_ready: gnt = 0 and all requesters stall. Operands are sampled only on the grant edge.
- A requester holding req high after a grant is re-arbitrated normally. It cannot win consecutively while another requester is requesting.
- res_ready is ignored while res_valid = 0.
- op_count increments on each res_valid & res_ready edge and saturates at 255.
- Reset values:
  - res_valid = 0
  - res_data = 0
  - res_id = 0
  - op_count = 0
  - last = NREQ-1, so requester 0 has top priority after reset
- gnt and busy follow from reset state and inputs.
- Reset asserted mid-operation discards the buffered result immediately; no transfer is counted.

## Timing
- Grant-to-result latency: 1 cycle. res_valid and res_data are valid the cycle after gnt.
- Throughput: 1 result/cycle while res_ready = 1 and any req is high.
- gnt depends combinationally on req, res_valid, res_ready and `last`. It has no path from op_a or op_b.
- res_data, res_id, res_valid and op_count are register outputs with no combinational input path.
- Fairness: with all NREQ requesting continuously and res_ready = 1, each requester is granted exactly once per NREQ cycles.
- Reset assertion takes effect without a clock edge. Deassertion is synchronous to clk, released by the integrating wrapper.

## Test plan
- Reset then single request: req=4'b0001, op_a[0]=4'b1100, op_b[0]=4'b1010, res_ready=1.
  - Expect gnt=4'b0001 in cycle 0.
  - Next cycle: res_valid=1, res_data=4'b0111, res_id=0, op_count=1 one edge later.
- All four requesting continuously, res_ready=1:
  - Grants 0,1,2,3,0,1,... one per cycle.
  - res_id follows the same order one cycle later.
- Backpressure: res_ready=0 with result buffered and req=4'b0110.
  - gnt=0 and res_data stable for 5 cycles.
  - Raise res_ready: same edge drains and grants requester 1, res_valid stays 1.
- Wrap and skip: last=2, req=4'b1011.
  - Grant order is 3, 0, 1, 3.
  - Requester 2 is never granted while its req=0.
- Async reset mid-stream: assert rst between edges while res_valid=1.
  - res_valid=0 and op_count=0 immediately.
  - After release with req=4'b1111, the first grant is requester 0.
- op_count saturation: 300 consecutive transfers → op_count=255 and holds at 255.
